// File: rtl/led_step_ctrl.sv
// Step-enable generator for the 4-LED running light: debounced key cycles the
// mode FWD -> REV -> PAUSE, and a free-running divider paces the step pulses.
module led_step_ctrl #(
    parameter int PERIOD = 50_000_000,
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic step,
    output logic dir,
    output logic run,
    output logic key_press
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(PERIOD - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYC - 1);

    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_PRESS_WAIT,
        DB_PRESSED,
        DB_RELEASE_WAIT
    } db_state_t;

    typedef enum logic [1:0] {
        M_FWD,
        M_REV,
        M_PAUSE
    } mode_t;

    logic          r_sync1;
    logic          r_sync2;
    db_state_t     r_db_state;
    logic [DW-1:0] r_db_cnt;
    mode_t         r_mode;
    logic [PW-1:0] r_div_cnt;
    logic          w_key_s;

    assign w_key_s = r_sync2;

    // Synchroniser idles at 1 so a reset never looks like a press edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_state <= DB_RELEASED;
            r_db_cnt   <= '0;
            key_press  <= 1'b0;
        end else begin
            key_press <= 1'b0;
            case (r_db_state)
                DB_RELEASED: begin
                    if (!w_key_s) begin
                        r_db_state <= DB_PRESS_WAIT;
                        r_db_cnt   <= '0;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (w_key_s) begin
                        r_db_state <= DB_RELEASED;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_db_state <= DB_PRESSED;
                        key_press  <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                DB_PRESSED: begin
                    if (w_key_s) begin
                        r_db_state <= DB_RELEASE_WAIT;
                        r_db_cnt   <= '0;
                    end
                end
                DB_RELEASE_WAIT: begin
                    if (!w_key_s) begin
                        r_db_state <= DB_PRESSED;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_db_state <= DB_RELEASED;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_db_state <= DB_RELEASED;
                    r_db_cnt   <= '0;
                end
            endcase
        end
    end

    // A mode change takes priority over a divider wrap in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= M_FWD;
            dir       <= 1'b0;
            run       <= 1'b1;
            step      <= 1'b0;
            r_div_cnt <= '0;
        end else if (key_press) begin
            r_div_cnt <= '0;
            step      <= 1'b0;
            case (r_mode)
                M_FWD: begin
                    r_mode <= M_REV;
                    dir    <= 1'b1;
                    run    <= 1'b1;
                end
                M_REV: begin
                    r_mode <= M_PAUSE;
                    dir    <= 1'b1;
                    run    <= 1'b0;
                end
                default: begin
                    r_mode <= M_FWD;
                    dir    <= 1'b0;
                    run    <= 1'b1;
                end
            endcase
        end else if (run) begin
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
                step      <= 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
                step      <= 1'b0;
            end
        end else begin
            r_div_cnt <= '0;
            step      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Bench for led_step_ctrl: directed scenarios plus random key activity, checked
// every cycle against a run-length/phase reference model.
module tb_led_step_ctrl;

    localparam int PERIOD = 4;
    localparam int DB_CYC = 3;

    logic clk;
    logic rst;
    logic key_n;
    logic step;
    logic dir;
    logic run;
    logic key_press;

    int n_vec = 0;
    int n_err = 0;

    led_step_ctrl #(.PERIOD(PERIOD), .DB_CYC(DB_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .step     (step),
        .dir      (dir),
        .run      (run),
        .key_press(key_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: key level flips after DB_CYC+1 consecutive opposite
    // synchronised samples; mode is 0/1/2; step fires every PERIOD-th edge of
    // the phase count since the last reset or mode change.
    logic m_d1, m_d2, m_lvl, m_kp, m_step;
    int   m_run_len, m_mode, m_phase;

    always @(posedge clk or posedge rst) begin : mdl
        int rl;
        bit flip;
        if (rst) begin
            m_d1      <= 1'b1;
            m_d2      <= 1'b1;
            m_lvl     <= 1'b1;
            m_run_len <= 0;
            m_kp      <= 1'b0;
            m_mode    <= 0;
            m_phase   <= 0;
            m_step    <= 1'b0;
        end else begin
            rl   = (m_d2 != m_lvl) ? m_run_len + 1 : 0;
            flip = (rl == DB_CYC + 1);
            m_run_len <= flip ? 0 : rl;
            if (flip) m_lvl <= m_d2;
            m_kp <= flip && (m_d2 == 1'b0);
            if (m_kp) begin
                m_mode  <= (m_mode + 1) % 3;
                m_phase <= 0;
                m_step  <= 1'b0;
            end else if (m_mode != 2) begin
                m_phase <= m_phase + 1;
                m_step  <= ((m_phase + 1) % PERIOD == 0);
            end else begin
                m_phase <= 0;
                m_step  <= 1'b0;
            end
            m_d2 <= m_d1;
            m_d1 <= key_n;
        end
    end

    always @(negedge clk) begin
        chk("step", step, m_step);
        chk("dir", dir, (m_mode != 0));
        chk("run", run, (m_mode != 2));
        chk("key_press", key_press, m_kp);
    end

    task automatic idle(input int n);
        key_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int low, input int high);
        key_n = 1'b0;
        repeat (low) @(negedge clk);
        key_n = 1'b1;
        repeat (high) @(negedge clk);
    endtask

    initial begin : stim
        int old_mode;
        int tries;
        rst   = 1'b1;
        key_n = 1'b1;
        #12;
        chk("rst_step", step, 1'b0);
        chk("rst_dir", dir, 1'b0);
        chk("rst_run", run, 1'b1);
        chk("rst_kp", key_press, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Free-running cadence in FWD
        idle(20);

        // Short bounces must be rejected
        for (int i = 0; i < 10; i++) press($urandom_range(1, 2), 3);
        idle(6);

        // Long hold: single accepted press, no press on release
        press(10, 12);

        // Three clean presses, lingering in PAUSE
        press(6, 8);
        idle(25);
        press(6, 8);
        press(6, 14);

        // Press timed so key_press lands on the divider wrap
        tries = 0;
        while (!((m_mode != 2) && (m_phase % PERIOD == 1) && m_lvl && m_d1 && m_d2 && m_run_len == 0)
               && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        chk("collision_setup", (tries < 100), 1'b1);
        old_mode = m_mode;
        key_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("collision_kp", key_press, 1'b1);
        @(negedge clk);
        chk("collision_step", step, 1'b0);
        chk("collision_run", run, (((old_mode + 1) % 3) != 2));
        chk("collision_dir", dir, (((old_mode + 1) % 3) != 0));
        key_n = 1'b1;
        idle(12);

        // Make sure we are stepping, then reset mid-period and mid-debounce
        while (m_mode != 0) press(6, 8);
        idle(5);
        key_n = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_step", step, 1'b0);
        chk("arst_dir", dir, 1'b0);
        chk("arst_run", run, 1'b1);
        chk("arst_kp", key_press, 1'b0);
        key_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(20);

        // Random key activity
        for (int i = 0; i < 40; i++) press($urandom_range(1, 8), $urandom_range(1, 10));
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
